// File: rtl/seq_pattern_detector.sv
// Programmable serial bit-pattern detector with a saturating match counter.
// Optional SEQDET_TIMESTAMP_EN records the bit index of the most recent match on match_pos.
module seq_pattern_detector #(
   parameter int               PAT_W   = 4,
   parameter int               CNT_W   = 8,
   parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(4'b0101),
   parameter int               DEF_LEN = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         din_valid,
   input  logic                         din,
   input  logic                         cfg_load,
   input  logic [PAT_W-1:0]             pat,
   input  logic [$clog2(PAT_W+1)-1:0]   pat_len,
   input  logic                         overlap_en,
   input  logic                         clr_cnt,
   output logic                         match,
   output logic [CNT_W-1:0]             match_cnt,
   output logic                         cnt_ovf,
   output logic [15:0]                  match_pos
);

   localparam int               LEN_W   = $clog2(PAT_W+1);
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

   typedef enum logic {S_FILL, S_HUNT} state_t;

   state_t           state_q;
   logic [PAT_W-1:0] cfgPat_q;
   logic [LEN_W-1:0] cfgLen_q;
   logic [PAT_W-2:0] hist_q;
   logic [LEN_W-1:0] fill_q;
   logic             match_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ovf_q;

   logic [LEN_W-1:0] loadLen_d;
   logic [PAT_W-1:0] window_d;
   logic [LEN_W-1:0] fill_d;
   logic [PAT_W-1:0] lenMask;
   logic             winHit;
   logic             compareNow;
   logic             matchNow;

   // Only PAT_W-1 history bits are kept: the oldest bit of a full window is the
   // one that would be shifted out, so it never takes part in a compare.
   always_comb begin
      loadLen_d = pat_len;
      if (pat_len == '0 || pat_len > MAX_LEN) begin
         loadLen_d = MAX_LEN;
      end
      window_d = {hist_q, din};
      fill_d   = (fill_q < MAX_LEN) ? fill_q + 1'b1 : fill_q;
      lenMask  = '0;
      for (int i = 0; i < PAT_W; i++) begin
         lenMask[i] = (LEN_W'(i) < cfgLen_q);
      end
      winHit     = ((window_d ^ cfgPat_q) & lenMask) == '0;
      compareNow = (state_q == S_HUNT) || (fill_d == cfgLen_q);
      matchNow   = din_valid && !cfg_load && compareNow && winHit;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_FILL;
         cfgPat_q <= DEF_PAT;
         cfgLen_q <= LEN_W'(DEF_LEN);
         hist_q   <= '0;
         fill_q   <= '0;
         match_q  <= 1'b0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         match_q <= matchNow;
         if (cfg_load) begin
            cfgPat_q <= pat;
            cfgLen_q <= loadLen_d;
            hist_q   <= '0;
            fill_q   <= '0;
            state_q  <= S_FILL;
         end else if (din_valid) begin
            hist_q <= window_d[PAT_W-2:0];
            if (matchNow && !overlap_en) begin
               fill_q  <= '0;
               state_q <= S_FILL;
            end else begin
               fill_q <= fill_d;
               if (compareNow) begin
                  state_q <= S_HUNT;
               end
            end
         end
         // A clear in the same cycle as a match still lets the pulse through.
         if (clr_cnt) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
         end else if (matchNow) begin
            if (&cnt_q) begin
               ovf_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

   assign match     = match_q;
   assign match_cnt = cnt_q;
   assign cnt_ovf   = ovf_q;

`ifdef SEQDET_TIMESTAMP_EN
   logic [15:0] bitIdx_q;
   logic [15:0] pos_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bitIdx_q <= '0;
         pos_q    <= '0;
      end else begin
         if (cfg_load) begin
            bitIdx_q <= '0;
         end else if (din_valid) begin
            bitIdx_q <= bitIdx_q + 16'd1;
         end
         if (matchNow) begin
            pos_q <= bitIdx_q;
         end
      end
   end

   assign match_pos = pos_q;
`else
   assign match_pos = 16'd0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scoreboard bench for seq_pattern_detector: stimulus queues expected match records,
// a monitor pops one per match pulse and compares count/overflow/position.
module tb_seq_pattern_detector;

   localparam int PAT_W = 4;
   localparam int CNT_W = 2;
   localparam int LEN_W = $clog2(PAT_W+1);

   logic             clk        = 1'b0;
   logic             rst        = 1'b0;
   logic             din_valid  = 1'b0;
   logic             din        = 1'b0;
   logic             cfg_load   = 1'b0;
   logic [PAT_W-1:0] pat        = '0;
   logic [LEN_W-1:0] pat_len    = '0;
   logic             overlap_en = 1'b1;
   logic             clr_cnt    = 1'b0;
   logic             match;
   logic [CNT_W-1:0] match_cnt;
   logic             cnt_ovf;
   logic [15:0]      match_pos;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int cnt;
      int ovf;
      int pos;
   } exp_t;

   exp_t expQ[$];
   exp_t monE;

   always #5 clk = ~clk;

   seq_pattern_detector #(
      .PAT_W   (PAT_W),
      .CNT_W   (CNT_W),
      .DEF_PAT (4'b0101),
      .DEF_LEN (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .din_valid  (din_valid),
      .din        (din),
      .cfg_load   (cfg_load),
      .pat        (pat),
      .pat_len    (pat_len),
      .overlap_en (overlap_en),
      .clr_cnt    (clr_cnt),
      .match      (match),
      .match_cnt  (match_cnt),
      .cnt_ovf    (cnt_ovf),
      .match_pos  (match_pos)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   function automatic int ts(input int p);
`ifdef SEQDET_TIMESTAMP_EN
      return p;
`else
      return 0 * p;
`endif
   endfunction

   // Every match pulse must correspond to exactly one queued expectation.
   always @(negedge clk) begin
      if (rst && match) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedMatch", 32'(match), 32'd0);
         end else begin
            monE = expQ.pop_front();
            checkOutput("matchCnt", 32'(match_cnt), 32'(monE.cnt));
            checkOutput("cntOvf",   32'(cnt_ovf),   32'(monE.ovf));
            checkOutput("matchPos", 32'(match_pos), 32'(monE.pos));
         end
      end
   end

   task automatic applyStimulus(input logic b, input bit expM, input int eCnt, input int eOvf, input int ePos);
      din_valid = 1'b1;
      din       = b;
      if (expM) begin
         expQ.push_back('{cnt: eCnt, ovf: eOvf, pos: ePos});
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      din_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic doReset();
      @(negedge clk);
      din_valid = 1'b0;
      cfg_load  = 1'b0;
      clr_cnt   = 1'b0;
      rst       = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic clearCount();
      clr_cnt = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
   endtask

   task automatic loadConfig(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic dropValid, input logic dropBit);
      cfg_load  = 1'b1;
      pat       = p;
      pat_len   = l;
      din_valid = dropValid;
      din       = dropBit;
      @(negedge clk);
      cfg_load  = 1'b0;
      din_valid = 1'b0;
   endtask

   task automatic endTest(input string name);
      idle(3);
      checkOutput({name, ".pending"}, 32'(expQ.size()), 32'd0);
      expQ.delete();
   endtask

   initial begin
      @(negedge clk);
      checkOutput("reset.match",    32'(match),     32'd0);
      checkOutput("reset.cnt",      32'(match_cnt), 32'd0);
      checkOutput("reset.ovf",      32'(cnt_ovf),   32'd0);
      checkOutput("reset.pos",      32'(match_pos), 32'd0);
      rst = 1'b1;

      // T1: default "101", overlapping
      doReset();
      overlap_en = 1'b1;
      applyStimulus(1'b1, 0, 0, 0, 0);
      applyStimulus(1'b0, 0, 0, 0, 0);
      applyStimulus(1'b1, 1, 1, 0, ts(2));
      applyStimulus(1'b0, 0, 0, 0, 0);
      applyStimulus(1'b1, 1, 2, 0, ts(4));
      endTest("t1");
      checkOutput("t1.cnt", 32'(match_cnt), 32'd2);

      // T2: same stream, non-overlapping
      doReset();
      overlap_en = 1'b0;
      applyStimulus(1'b1, 0, 0, 0, 0);
      applyStimulus(1'b0, 0, 0, 0, 0);
      applyStimulus(1'b1, 1, 1, 0, ts(2));
      applyStimulus(1'b0, 0, 0, 0, 0);
      applyStimulus(1'b1, 0, 0, 0, 0);
      endTest("t2");
      checkOutput("t2.cnt", 32'(match_cnt), 32'd1);

      // T3: gaps of two idle cycles between valid bits
      doReset();
      overlap_en = 1'b1;
      applyStimulus(1'b1, 0, 0, 0, 0);
      idle(2);
      applyStimulus(1'b0, 0, 0, 0, 0);
      idle(2);
      applyStimulus(1'b1, 1, 1, 0, ts(2));
      idle(1);
      checkOutput("t3.pulseWidth", 32'(match), 32'd0);
      endTest("t3");

      // T4: 2-bit counter saturates on the fourth match
      doReset();
      overlap_en = 1'b1;
      applyStimulus(1'b1, 0, 0, 0, 0);
      for (int k = 1; k <= 6; k++) begin
         applyStimulus(1'b0, 0, 0, 0, 0);
         applyStimulus(1'b1, 1, (k < 3) ? k : 3, (k > 3) ? 1 : 0, ts(2 * k));
      end
      endTest("t4");
      checkOutput("t4.cnt", 32'(match_cnt), 32'd3);
      checkOutput("t4.ovf", 32'(cnt_ovf),   32'd1);
      clearCount();
      checkOutput("t4.clrCnt", 32'(match_cnt), 32'd0);
      checkOutput("t4.clrOvf", 32'(cnt_ovf),   32'd0);

      // T5: reconfigure mid-stream, bit sent with cfg_load is dropped
      doReset();
      overlap_en = 1'b1;
      applyStimulus(1'b1, 0, 0, 0, 0);
      applyStimulus(1'b0, 0, 0, 0, 0);
      loadConfig(4'b1101, 3'd4, 1'b1, 1'b1);
      applyStimulus(1'b1, 0, 0, 0, 0);
      applyStimulus(1'b1, 0, 0, 0, 0);
      applyStimulus(1'b0, 0, 0, 0, 0);
      applyStimulus(1'b1, 1, 1, 0, ts(3));
      endTest("t5");

      // Dropped bit would otherwise complete 1101 with the following 1,0,1
      loadConfig(4'b1101, 3'd4, 1'b1, 1'b1);
      applyStimulus(1'b1, 0, 0, 0, 0);
      applyStimulus(1'b0, 0, 0, 0, 0);
      applyStimulus(1'b1, 0, 0, 0, 0);
      endTest("t5b");

      // pat_len of 0 clamps to the full width
      loadConfig(4'b1101, 3'd0, 1'b0, 1'b0);
      applyStimulus(1'b1, 0, 0, 0, 0);
      applyStimulus(1'b1, 0, 0, 0, 0);
      applyStimulus(1'b0, 0, 0, 0, 0);
      applyStimulus(1'b1, 1, 2, 0, ts(3));
      endTest("t5c");

      // T7: single-bit pattern, non-overlapping; counter survives cfg_load
      overlap_en = 1'b0;
      loadConfig(4'b0001, 3'd1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1, 3, 0, ts(0));
      applyStimulus(1'b0, 0, 0, 0, 0);
      applyStimulus(1'b1, 1, 3, 1, ts(2));
      endTest("t7");

      // T8: clear coinciding with a match
      clearCount();
      checkOutput("t8.clrCnt", 32'(match_cnt), 32'd0);
      applyStimulus(1'b1, 1, 1, 0, ts(3));
      clr_cnt = 1'b1;
      applyStimulus(1'b1, 1, 0, 0, ts(4));
      clr_cnt = 1'b0;
      applyStimulus(1'b1, 1, 1, 0, ts(5));
      endTest("t8");

      // T6: asynchronous reset mid-pattern loses the partial match
      doReset();
      overlap_en = 1'b1;
      applyStimulus(1'b1, 0, 0, 0, 0);
      applyStimulus(1'b0, 0, 0, 0, 0);
      applyStimulus(1'b1, 1, 1, 0, ts(2));
      applyStimulus(1'b1, 0, 0, 0, 0);
      applyStimulus(1'b0, 0, 0, 0, 0);
      din_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      checkOutput("t6.asyncCnt", 32'(match_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(1'b1, 0, 0, 0, 0);
      idle(2);
      applyStimulus(1'b0, 0, 0, 0, 0);
      applyStimulus(1'b1, 1, 1, 0, ts(2));
      endTest("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
